// File: rtl/uart_dev_bridge_if.sv
// UART byte stream plus device-bus initiator signals seen by uart_dev_bridge.
// master = the bridge, slave = the UART/bus environment around it.
interface uart_dev_bridge_if;
  logic        rxdReady_i;
  logic [7:0]  rxdData_i;
  logic        txdBusy_i;
  logic        txdStart_o;
  logic [7:0]  txdData_o;
  logic        devEnable_o;
  logic        devWrite_o;
  logic        devBusy_i;
  logic [31:0] devDataSave_o;
  logic [31:0] devDataLoad_i;
  logic [31:0] devPhysicalAddr_o;
  logic [3:0]  devByteSelect_o;

  modport master (
    input  rxdReady_i, rxdData_i, txdBusy_i, devBusy_i, devDataLoad_i,
    output txdStart_o, txdData_o, devEnable_o, devWrite_o,
           devDataSave_o, devPhysicalAddr_o, devByteSelect_o
  );

  modport slave (
    output rxdReady_i, rxdData_i, txdBusy_i, devBusy_i, devDataLoad_i,
    input  txdStart_o, txdData_o, devEnable_o, devWrite_o,
           devDataSave_o, devPhysicalAddr_o, devByteSelect_o
  );
endinterface

// File: rtl/uart_dev_bridge.sv
// UART-driven debug/loader initiator: decodes 'W'/'R' frames into 32-bit bus accesses.
// Optional BRIDGE_CHECKSUM_EN adds a trailing XOR checksum byte to every frame.
module uart_dev_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 25000000,
  parameter logic [7:0]  CMD_WRITE      = 8'h57,
  parameter logic [7:0]  CMD_READ       = 8'h52,
  parameter logic [7:0]  ACK_BYTE       = 8'h4B
) (
  input  logic              clk,
  input  logic              rst,
  uart_dev_bridge_if.master bus_if,
  output logic              active_o
);

  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [7:0]  ERR_BYTE = 8'h45;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
`ifdef BRIDGE_CHECKSUM_EN
    CSUM,
`endif
    BUS,
    TX_BYTE,
    TX_GAP,
    TX_WAIT
  } state_t;

  state_t            state_q;
  logic              write_q;
  logic [1:0]        cnt_q;
  logic [1:0]        last_q;
  logic [TO_W-1:0]   to_q;
  logic [31:0]       addr_q;
  logic [31:0]       data_q;
  logic [31:0]       resp_q;
  logic              txd_start_q;
  logic [7:0]        txd_data_q;
  logic              dev_en_q;
  logic [3:0]        bsel_q;
  logic              active_q;
`ifdef BRIDGE_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic              rx_c;
  logic              rx_last_d;
  logic              in_frame_d;
  logic              go_bus_d;

  // Frame-level decode shared by the byte collector, timeout and bus launch.
  always_comb begin
    rx_c       = bus_if.rxdReady_i;
    rx_last_d  = rx_c && (cnt_q == 2'd3);
    in_frame_d = (state_q == ADDR) || (state_q == WDATA);
`ifdef BRIDGE_CHECKSUM_EN
    in_frame_d = in_frame_d || (state_q == CSUM);
    go_bus_d   = (state_q == CSUM) && rx_c && (bus_if.rxdData_i == csum_q);
`else
    go_bus_d   = rx_last_d && (((state_q == ADDR) && !write_q) || (state_q == WDATA));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      cnt_q       <= 2'd0;
      last_q      <= 2'd0;
      to_q        <= '0;
      addr_q      <= 32'h0;
      data_q      <= 32'h0;
      resp_q      <= 32'h0;
      txd_start_q <= 1'b0;
      txd_data_q  <= 8'h0;
      dev_en_q    <= 1'b0;
      bsel_q      <= 4'h0;
      active_q    <= 1'b0;
`ifdef BRIDGE_CHECKSUM_EN
      csum_q      <= 8'h0;
`endif
    end else begin
      txd_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_c && ((bus_if.rxdData_i == CMD_WRITE) || (bus_if.rxdData_i == CMD_READ))) begin
            write_q  <= (bus_if.rxdData_i == CMD_WRITE);
            cnt_q    <= 2'd0;
            to_q     <= '0;
            active_q <= 1'b1;
            state_q  <= ADDR;
`ifdef BRIDGE_CHECKSUM_EN
            csum_q   <= bus_if.rxdData_i;
`endif
          end
        end
        ADDR: begin
          if (rx_c) begin
            addr_q[{cnt_q, 3'b000} +: 8] <= bus_if.rxdData_i;
            cnt_q <= cnt_q + 2'd1;
`ifdef BRIDGE_CHECKSUM_EN
            csum_q <= csum_q ^ bus_if.rxdData_i;
`endif
            if (rx_last_d) begin
              if (write_q) state_q <= WDATA;
`ifdef BRIDGE_CHECKSUM_EN
              else state_q <= CSUM;
`endif
            end
          end
        end
        WDATA: begin
          if (rx_c) begin
            data_q[{cnt_q, 3'b000} +: 8] <= bus_if.rxdData_i;
            cnt_q <= cnt_q + 2'd1;
`ifdef BRIDGE_CHECKSUM_EN
            csum_q <= csum_q ^ bus_if.rxdData_i;
            if (rx_last_d) state_q <= CSUM;
`endif
          end
        end
`ifdef BRIDGE_CHECKSUM_EN
        CSUM: begin
          // Bad checksum: skip the bus and answer with a single error byte.
          if (rx_c && (bus_if.rxdData_i != csum_q)) begin
            resp_q  <= {24'h0, ERR_BYTE};
            last_q  <= 2'd0;
            cnt_q   <= 2'd0;
            state_q <= TX_BYTE;
          end
        end
`endif
        BUS: begin
          if (!bus_if.devBusy_i) begin
            dev_en_q <= 1'b0;
            bsel_q   <= 4'h0;
            resp_q   <= write_q ? {24'h0, ACK_BYTE} : bus_if.devDataLoad_i;
            last_q   <= write_q ? 2'd0 : 2'd3;
            cnt_q    <= 2'd0;
            state_q  <= TX_BYTE;
          end
        end
        TX_BYTE: begin
          if (!bus_if.txdBusy_i) begin
            txd_start_q <= 1'b1;
            txd_data_q  <= resp_q[{cnt_q, 3'b000} +: 8];
            state_q     <= TX_GAP;
          end
        end
        TX_GAP: state_q <= TX_WAIT;
        TX_WAIT: begin
          if (!bus_if.txdBusy_i) begin
            if (cnt_q == last_q) begin
              active_q <= 1'b0;
              state_q  <= IDLE;
            end else begin
              cnt_q   <= cnt_q + 2'd1;
              state_q <= TX_BYTE;
            end
          end
        end
        default: begin
          active_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase

      // Inter-byte silence watchdog while a frame is being collected.
      if (in_frame_d) begin
        if (rx_c) begin
          to_q <= '0;
        end else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          to_q     <= '0;
          active_q <= 1'b0;
          state_q  <= IDLE;
        end else begin
          to_q <= to_q + TO_W'(1);
        end
      end

      if (go_bus_d) begin
        dev_en_q <= 1'b1;
        bsel_q   <= 4'hF;
        state_q  <= BUS;
      end
    end
  end

  assign bus_if.txdStart_o        = txd_start_q;
  assign bus_if.txdData_o         = txd_data_q;
  assign bus_if.devEnable_o       = dev_en_q;
  assign bus_if.devWrite_o        = write_q;
  assign bus_if.devDataSave_o     = data_q;
  assign bus_if.devPhysicalAddr_o = addr_q;
  assign bus_if.devByteSelect_o   = bsel_q;
  assign active_o                 = active_q;

endmodule
